user_ip_apb_arb: RTL and testbench
==================================

Name: user_ip_apb_arb

Overview:
Two-master APB4 arbiter in front of a single user IP APB slave slot. Master 0 is the SoC CPU bridge and master 1 is a secondary requester (DMA or debug). The block round-robin arbitrates between them, re-sequences the winning transfer onto the slave through an explicit SETUP/ACCESS state machine, and returns the response to the winner only. A watchdog aborts slave transfers that stall, and the block counts those timeouts.

Parameters:
AW, 8, address width on all ports (user IP decodes paddr[7:0])
DW, 32, data width; strobe width is DW/8
TIMEOUT_CYC, 16, maximum ACCESS cycles allowed without s_pready; 0 disables the watchdog

Ports:
clk_i  in  1  clock; all logic is on the rising edge
rst_n_i  in  1  reset; synchronous, active-low
mX_psel  in  1  master X select, X = 0,1 (all mX_ ports exist for both masters)
mX_penable  in  1  master X enable
mX_pwrite  in  1  master X write
mX_paddr  in  AW  master X address
mX_pwdata  in  DW  master X write data
mX_pstrb  in  DW/8  master X strobes
mX_prdata  out  DW  read data returned to master X
mX_pready  out  1  ready to master X
mX_pslverr  out  1  error to master X
s_psel  out  1  slave select
s_penable  out  1  slave enable
s_pwrite  out  1  slave write
s_paddr  out  AW  slave address
s_pwdata  out  DW  slave write data
s_pstrb  out  DW/8  slave strobes
s_prdata  in  DW  slave read data
s_pready  in  1  slave ready
s_pslverr  in  1  slave error
gnt_o  out  2  one-hot current owner; 0 when idle
busy_o  out  1  high in SETUP or ACCESS
tmo_cnt_o  out  8  saturating count of watchdog aborts

Behaviour:
- Reset (rst_n_i low at an edge):
  - FSM goes to IDLE; last_gnt = 1, so master 0 wins the first tie.
  - Watchdog counter and tmo_cnt_o clear to 0.
  - All s_* outputs, all m*_* outputs, gnt_o and busy_o are 0.
  - A reset during SETUP or ACCESS abandons the transfer. No pready is returned.
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - A request is mX_psel = 1.
  - If both masters request, grant the master other than last_gnt. Otherwise grant the single requester.
  - On grant, latch pwrite, paddr, pwdata and pstrb from the winner. Update last_gnt and go to SETUP.
- SETUP: exactly one cycle. s_psel = 1, s_penable = 0, s_* driven from the latched values. Then go to ACCESS.
- ACCESS:
  - s_psel = 1 and s_penable = 1; the watchdog counter increments each cycle.
  - When s_pready = 1, drive the winner's mX_pready = 1 combinationally in that cycle. mX_prdata = s_prdata and mX_pslverr = s_pslverr in the same cycle. Then go to IDLE.
  - When TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC - 1 without s_pready, abort:
    - winner gets pready = 1, pslverr = 1, prdata = 0;
    - s_psel drops next cycle;
    - tmo_cnt_o increments, saturating at 255;
    - FSM goes to IDLE.
- Latency:
  - Uncontended master sees pready 2 cycles after its setup cycle when the slave has zero wait states.
  - Back-to-back transfers from the same master have 1 IDLE cycle between them.
- Loser:
  - mX_pready = 0 while the other master is served. The loser must hold its request per APB.
  - The loser is served in the next IDLE cycle.
- Outside a response cycle, mX_prdata and mX_pslverr are 0 and only the granted master is ever acked.
- gnt_o is one-hot through SETUP and ACCESS and 0 in IDLE. busy_o = (state != IDLE).
- Requester drops psel mid-transfer (protocol violation): the slave transfer still completes and the response is discarded. No pready goes to that master.
- s_pready or s_pslverr seen outside ACCESS: ignored.
- s_pready in the same cycle the watchdog fires: normal completion wins. tmo_cnt_o is unchanged.

Test Plan:
- Single read: m0 reads paddr 0x00, slave returns 0x000000FF with zero wait states → s_psel rises at cycle 1, m0_pready at cycle 2, m0_prdata = 0xFF, gnt_o = 01.
- Contention: m0 and m1 request in the same cycle, both writing 0x04 (0xA5, 0x5A) → m0 served first, m1 SETUP immediately after the IDLE cycle, slave sees write order 0xA5 then 0x5A.
- Fairness: m0 and m1 both requesting continuously for 6 transfers → grants alternate 0,1,0,1,0,1; no master is acked twice in a row.
- Wait states: slave holds pready low for 5 ACCESS cycles → m0_pready stays low 5 cycles then pulses once; s_penable is held throughout.
- Watchdog: TIMEOUT_CYC = 4 and slave never readies → after 4 ACCESS cycles, m1 gets pslverr = 1 and prdata = 0, tmo_cnt_o = 1; the next m0 transfer completes normally.
- Mid-transfer reset: rst_n_i low during ACCESS → next cycle all outputs are 0 and the FSM is in IDLE; after release m0 still wins the first tie.

Source files
------------

// File: rtl/user_ip_apb_arb.sv
// Two-master APB4 round-robin arbiter in front of one user IP slave slot,
// with an ACCESS-phase watchdog and a saturating count of aborted transfers.
//
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   m0_*, m1_*              APB4 completer ports facing the two requesters
//   s_*                     APB4 requester port facing the user IP
//   gnt_o                   one-hot owner while busy, 0 when idle
//   busy_o                  high in SETUP or ACCESS
//   tmo_cnt_o               saturating count of watchdog aborts
module user_ip_apb_arb #(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            m0_psel,
  input  logic            m0_penable,
  input  logic            m0_pwrite,
  input  logic [AW-1:0]   m0_paddr,
  input  logic [DW-1:0]   m0_pwdata,
  input  logic [DW/8-1:0] m0_pstrb,
  output logic [DW-1:0]   m0_prdata,
  output logic            m0_pready,
  output logic            m0_pslverr,
  input  logic            m1_psel,
  input  logic            m1_penable,
  input  logic            m1_pwrite,
  input  logic [AW-1:0]   m1_paddr,
  input  logic [DW-1:0]   m1_pwdata,
  input  logic [DW/8-1:0] m1_pstrb,
  output logic [DW-1:0]   m1_prdata,
  output logic            m1_pready,
  output logic            m1_pslverr,
  output logic            s_psel,
  output logic            s_penable,
  output logic            s_pwrite,
  output logic [AW-1:0]   s_paddr,
  output logic [DW-1:0]   s_pwdata,
  output logic [DW/8-1:0] s_pstrb,
  input  logic [DW-1:0]   s_prdata,
  input  logic            s_pready,
  input  logic            s_pslverr,
  output logic [1:0]      gnt_o,
  output logic            busy_o,
  output logic [7:0]      tmo_cnt_o
);

  localparam int SW = DW / 8;
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            own_q, own_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   strb_q, strb_d;
  logic [CW-1:0]   wd_q, wd_d;
  logic [7:0]      tmo_q, tmo_d;
  logic            psel_q, psel_d;
  logic            pen_q, pen_d;
  logic [1:0]      gnt_q, gnt_d;

  logic [1:0] req;
  logic       win;
  logic       acc;
  logic       done_ok;
  logic       wd_fire;
  logic       rsp;

  assign req = {m1_psel, m0_psel};
  // On a tie the master that did not win last time goes next.
  assign win = (req == 2'b11) ? ~last_q : req[1];
  assign acc = (state_q == ACCESS);
  assign done_ok = acc && s_pready;
  // A ready slave in the firing cycle completes normally.
  assign wd_fire = (TIMEOUT_CYC != 0) && acc && !s_pready
                && (wd_q == CW'(TIMEOUT_CYC - 1));
  assign rsp = done_ok || wd_fire;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (|req) begin
          state_d = SETUP;
          own_d   = win;
          last_d  = win;
          wr_d    = win ? m1_pwrite : m0_pwrite;
          addr_d  = win ? m1_paddr  : m0_paddr;
          wdata_d = win ? m1_pwdata : m0_pwdata;
          strb_d  = win ? m1_pstrb  : m0_pstrb;
        end
      end
      SETUP: begin
        wd_d    = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (rsp) begin
          state_d = IDLE;
          if (wd_fire && tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    psel_d = (state_d != IDLE);
    pen_d  = (state_d == ACCESS);
    gnt_d  = psel_d ? (own_d ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      wd_q    <= '0;
      tmo_q   <= '0;
      psel_q  <= 1'b0;
      pen_q   <= 1'b0;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
      psel_q  <= psel_d;
      pen_q   <= pen_d;
      gnt_q   <= gnt_d;
    end
  end

  assign s_psel    = psel_q;
  assign s_penable = pen_q;
  assign s_pwrite  = wr_q;
  assign s_paddr   = addr_q;
  assign s_pwdata  = wdata_q;
  assign s_pstrb   = strb_q;
  assign gnt_o     = gnt_q;
  assign busy_o    = psel_q;
  assign tmo_cnt_o = tmo_q;

  // A requester that dropped psel mid-transfer gets no response.
  assign m0_pready  = rsp && !own_q && m0_psel;
  assign m1_pready  = rsp &&  own_q && m1_psel;
  assign m0_prdata  = (m0_pready && done_ok) ? s_prdata : '0;
  assign m1_prdata  = (m1_pready && done_ok) ? s_prdata : '0;
  assign m0_pslverr = m0_pready && (done_ok ? s_pslverr : 1'b1);
  assign m1_pslverr = m1_pready && (done_ok ? s_pslverr : 1'b1);

  // penable is implied by the arbiter's own sequencing.
  logic unused_pen;
  assign unused_pen = m0_penable ^ m1_penable;

endmodule

// File: tb/tb_user_ip_apb_arb.sv
// Bench for user_ip_apb_arb: directed scenarios then randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_user_ip_apb_arb;

  localparam int TMO = 6;

  logic        clk;
  logic        rst_n;
  logic [1:0]  m_psel, m_pen, m_pwr;
  logic [7:0]  m_addr [2];
  logic [31:0] m_wd [2];
  logic [3:0]  m_st [2];
  logic [31:0] m_rd [2];
  logic [1:0]  m_rdy, m_err;
  logic        s_psel, s_penable, s_pwrite;
  logic [7:0]  s_paddr;
  logic [31:0] s_pwdata, s_prdata;
  logic [3:0]  s_pstrb;
  logic        s_pready, s_pslverr;
  logic [1:0]  gnt;
  logic        busy;
  logic [7:0]  tmo_cnt;

  user_ip_apb_arb #(.AW(8), .DW(32), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_psel(m_psel[0]), .m0_penable(m_pen[0]), .m0_pwrite(m_pwr[0]),
    .m0_paddr(m_addr[0]), .m0_pwdata(m_wd[0]), .m0_pstrb(m_st[0]),
    .m0_prdata(m_rd[0]), .m0_pready(m_rdy[0]), .m0_pslverr(m_err[0]),
    .m1_psel(m_psel[1]), .m1_penable(m_pen[1]), .m1_pwrite(m_pwr[1]),
    .m1_paddr(m_addr[1]), .m1_pwdata(m_wd[1]), .m1_pstrb(m_st[1]),
    .m1_prdata(m_rd[1]), .m1_pready(m_rdy[1]), .m1_pslverr(m_err[1]),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .gnt_o(gnt), .busy_o(busy), .tmo_cnt_o(tmo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // requester shadows, applied at the next falling edge
  bit          act [2];
  bit          en [2];
  bit          wr [2];
  logic [7:0]  ad [2];
  logic [31:0] wd [2];
  logic [3:0]  st [2];
  int          p_start [2];
  bit          rst_req;
  int          rdy_pct, err_pct;
  bit          rd_fix_en;
  logic [31:0] rd_fix;

  // reference model: who owns the slave and for how many cycles
  bit          md_valid, md_busy, md_wr;
  int          md_own, md_last, md_age, md_tmo;
  logic [7:0]  md_addr;
  logic [31:0] md_wdata;
  logic [3:0]  md_st;

  int          ak_m [$];
  int          ak_c [$];
  logic [31:0] ak_r [$];
  bit          ak_e [$];
  logic [7:0]  sw_a [$];
  logic [31:0] sw_d [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ak_m.delete(); ak_c.delete(); ak_r.delete(); ak_e.delete();
    sw_a.delete(); sw_d.delete();
  endtask

  task automatic start_xfer(input int i, input bit w, input logic [7:0] a,
                            input logic [31:0] d);
    act[i] = 1; en[i] = 0; wr[i] = w; ad[i] = a; wd[i] = d; st[i] = 4'hF;
  endtask

  task automatic step();
    int w;
    bit ok, fire;
    logic [1:0]  e_rdy, e_err;
    logic [31:0] e_rd [2];
    @(negedge clk);
    rst_n = rst_req;
    for (int i = 0; i < 2; i++) begin
      m_psel[i] = act[i]; m_pen[i] = en[i]; m_pwr[i] = wr[i];
      m_addr[i] = ad[i]; m_wd[i] = wd[i]; m_st[i] = st[i];
    end
    s_pready  = ($urandom_range(99) < rdy_pct);
    s_prdata  = rd_fix_en ? rd_fix : $urandom();
    s_pslverr = ($urandom_range(99) < err_pct);
    #1;
    ok = 0; fire = 0; e_rdy = 0; e_err = 0; e_rd[0] = 0; e_rd[1] = 0;
    if (md_busy && md_age > 0) begin
      ok = s_pready;
      fire = (TMO != 0) && !s_pready && (md_age - 1 == TMO - 1);
    end
    if ((ok || fire) && m_psel[md_own]) begin
      e_rdy[md_own] = 1;
      e_rd[md_own]  = ok ? s_prdata : 32'h0;
      e_err[md_own] = ok ? s_pslverr : 1'b1;
    end
    if (md_valid) begin
      chk("gnt", gnt, md_busy ? (2'b01 << md_own) : 2'b00);
      chk("busy", busy, md_busy);
      chk("s_psel", s_psel, md_busy);
      chk("s_penable", s_penable, md_busy && md_age > 0);
      chk("tmo_cnt", tmo_cnt, md_tmo);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d_pready", i), m_rdy[i], e_rdy[i]);
        chk($sformatf("m%0d_prdata", i), m_rd[i], e_rd[i]);
        chk($sformatf("m%0d_pslverr", i), m_err[i], e_err[i]);
      end
      if (md_busy) begin
        chk("s_pwrite", s_pwrite, md_wr);
        chk("s_paddr", s_paddr, md_addr);
        chk("s_pwdata", s_pwdata, md_wdata);
        chk("s_pstrb", s_pstrb, md_st);
      end
    end
    if (!rst_n) begin
      md_valid = 1; md_busy = 0; md_last = 1; md_tmo = 0; md_age = 0;
      for (int i = 0; i < 2; i++) begin act[i] = 0; en[i] = 0; end
    end else if (md_valid) begin
      if (ok && md_wr) begin
        sw_a.push_back(md_addr); sw_d.push_back(md_wdata);
      end
      if (!md_busy) begin
        if (m_psel != 2'b00) begin
          w = (m_psel == 2'b11) ? 1 - md_last : (m_psel[0] ? 0 : 1);
          md_own = w; md_last = w; md_busy = 1; md_age = 0;
          md_wr = m_pwr[w]; md_addr = m_addr[w];
          md_wdata = m_wd[w]; md_st = m_st[w];
        end
      end else if (ok || fire) begin
        md_busy = 0;
        if (!ok && md_tmo < 255) md_tmo++;
      end else begin
        md_age++;
      end
      for (int i = 0; i < 2; i++) begin
        if (e_rdy[i]) begin
          act[i] = 0; en[i] = 0;
          ak_m.push_back(i); ak_c.push_back(cyc);
          ak_r.push_back(e_rd[i]); ak_e.push_back(e_err[i]);
        end else if (act[i]) begin
          en[i] = 1;
        end
        if (!act[i] && $urandom_range(99) < p_start[i]) begin
          act[i] = 1; en[i] = 0;
          wr[i] = 1'($urandom_range(1));
          ad[i] = 8'($urandom); wd[i] = $urandom(); st[i] = 4'($urandom);
        end
      end
    end
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (act[0] || act[1]); k++) step();
    chk("drain_timeout", {act[0], act[1]}, 2'b00);
  endtask

  initial begin
    int c0;
    rst_n = 0; rst_req = 0; rdy_pct = 100; err_pct = 0;
    rd_fix_en = 0; rd_fix = 0;
    md_valid = 0; md_busy = 0; md_wr = 0; md_own = 0; md_last = 1;
    md_age = 0; md_tmo = 0; md_addr = 0; md_wdata = 0; md_st = 0;
    m_psel = 0; m_pen = 0; m_pwr = 0;
    s_pready = 0; s_prdata = 0; s_pslverr = 0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; en[i] = 0; wr[i] = 0; ad[i] = 0; wd[i] = 0; st[i] = 0;
      p_start[i] = 0;
      m_addr[i] = 0; m_wd[i] = 0; m_st[i] = 0;
    end

    // reset state
    step(); step();
    rst_req = 1;
    step();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tmo", tmo_cnt, 8'd0);
    chk("rst_paddr", s_paddr, 8'd0);
    chk("rst_pwdata", s_pwdata, 32'd0);
    chk("rst_pstrb", s_pstrb, 4'd0);

    // contention: m0 first after reset, m1 right after one idle cycle
    clear_logs();
    start_xfer(0, 1, 8'h04, 32'hA5);
    start_xfer(1, 1, 8'h04, 32'h5A);
    c0 = cyc;
    drain();
    chk("cont_acks", ak_m.size(), 2);
    if (ak_m.size() == 2) begin
      chk("cont_first", ak_m[0], 0);
      chk("cont_t0", ak_c[0], c0 + 2);
      chk("cont_t1", ak_c[1], c0 + 5);
    end
    chk("cont_writes", sw_d.size(), 2);
    if (sw_d.size() == 2) begin
      chk("cont_w0", sw_d[0], 32'hA5);
      chk("cont_w1", sw_d[1], 32'h5A);
    end

    // single zero-wait read
    clear_logs();
    rd_fix_en = 1; rd_fix = 32'h0000_00FF;
    start_xfer(0, 0, 8'h00, 32'h0);
    c0 = cyc;
    drain();
    rd_fix_en = 0;
    chk("rd_acks", ak_m.size(), 1);
    if (ak_m.size() == 1) begin
      chk("rd_cycle", ak_c[0], c0 + 2);
      chk("rd_data", ak_r[0], 32'hFF);
      chk("rd_err", ak_e[0], 1'b0);
    end

    // five wait states, ready lands on the watchdog's last cycle
    clear_logs();
    rdy_pct = 0;
    start_xfer(0, 0, 8'h20, 32'h0);
    c0 = cyc;
    for (int k = 0; k < 7; k++) step();
    chk("ws_early", ak_m.size(), 0);
    rdy_pct = 100;
    drain();
    chk("ws_acks", ak_m.size(), 1);
    if (ak_m.size() == 1) begin
      chk("ws_cycle", ak_c[0], c0 + 7);
      chk("ws_err", ak_e[0], 1'b0);
    end
    step();
    chk("ws_tmo", tmo_cnt, 8'd0);

    // watchdog abort on m1, then a normal m0 transfer
    clear_logs();
    rdy_pct = 0;
    start_xfer(1, 0, 8'h30, 32'h0);
    c0 = cyc;
    drain();
    chk("wd_acks", ak_m.size(), 1);
    if (ak_m.size() == 1) begin
      chk("wd_master", ak_m[0], 1);
      chk("wd_cycle", ak_c[0], c0 + 1 + TMO);
      chk("wd_err", ak_e[0], 1'b1);
      chk("wd_data", ak_r[0], 32'h0);
    end
    step();
    chk("wd_cnt", tmo_cnt, 8'd1);
    clear_logs();
    rdy_pct = 100;
    start_xfer(0, 1, 8'h34, 32'h1234);
    c0 = cyc;
    drain();
    chk("wd_after", ak_m.size(), 1);
    if (ak_m.size() == 1) begin
      chk("wd_after_t", ak_c[0], c0 + 2);
      chk("wd_after_err", ak_e[0], 1'b0);
    end

    // requester abandons mid-transfer
    clear_logs();
    rdy_pct = 0;
    start_xfer(1, 1, 8'h10, 32'hCAFE);
    for (int k = 0; k < 3; k++) step();
    act[1] = 0; en[1] = 0;
    rdy_pct = 100;
    step(); step();
    chk("drop_acks", ak_m.size(), 0);
    chk("drop_slave", sw_d.size(), 1);
    chk("drop_busy", busy, 1'b0);

    // reset in ACCESS
    rdy_pct = 0;
    start_xfer(0, 0, 8'h40, 32'h0);
    for (int k = 0; k < 3; k++) step();
    rst_req = 0;
    step();
    rst_req = 1;
    step();
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_gnt", gnt, 2'b00);
    chk("mrst_psel", s_psel, 1'b0);
    chk("mrst_rdy", m_rdy, 2'b00);
    chk("mrst_tmo", tmo_cnt, 8'd0);
    clear_logs();
    rdy_pct = 100;
    start_xfer(0, 0, 8'h44, 32'h0);
    start_xfer(1, 0, 8'h48, 32'h0);
    drain();
    if (ak_m.size() > 0) chk("mrst_tie", ak_m[0], 0);
    else chk("mrst_tie_none", ak_m.size(), 2);

    // fairness under continuous contention
    clear_logs();
    p_start[0] = 100; p_start[1] = 100;
    for (int k = 0; k < 60 && ak_m.size() < 6; k++) step();
    p_start[0] = 0; p_start[1] = 0;
    drain();
    chk("fair_n", ak_m.size() >= 6, 1'b1);
    for (int k = 0; k < 6 && k < ak_m.size(); k++)
      chk($sformatf("fair_%0d", k), ak_m[k], k % 2);

    // timeout counter saturation
    p_start[0] = 100; rdy_pct = 0;
    for (int k = 0; k < 3000 && md_tmo < 255; k++) step();
    for (int k = 0; k < 30; k++) step();
    chk("tmo_sat", tmo_cnt, 8'd255);
    p_start[0] = 0; rdy_pct = 100;
    drain();

    // randomized traffic
    err_pct = 25;
    for (int b = 0; b < 15; b++) begin
      p_start[0] = $urandom_range(100, 20);
      p_start[1] = $urandom_range(100, 20);
      rdy_pct = $urandom_range(100, 30);
      for (int k = 0; k < 200; k++) step();
    end
    p_start[0] = 0; p_start[1] = 0; rdy_pct = 100;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
